// File: rtl/pipeline_hazard_unit_pkg.sv
`default_nettype none
// Shared architectural defines for the in-order pipeline: stage sizing, the
// per-stage tuple layout and the hard-wired zero register.
package pipeline_hazard_unit_pkg;

  localparam int STAGES_DEFAULT = 3;
  localparam int STAGES_MIN     = 2;
  localparam int STAGES_MAX     = 8;
  localparam int STAGE_IDX_W    = 3;
  localparam int INFLIGHT_W     = 4;

  localparam int REG_ZERO       = 0;

  // Tuple layout, MSB first: {valid, we, is_jump, dst[REG_AW-1:0]}
  localparam int TUPLE_CTRL_W   = 3;

  function automatic int tuple_width(input int reg_aw);
    return reg_aw + TUPLE_CTRL_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_unit_compare.sv
`default_nettype none
// hazard_compare: one in-flight stage tuple against both issue sources.
// Reports a RAW match only for a live write to a non-zero register.
module hazard_compare
  import pipeline_hazard_unit_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              check_en,
  input  logic              stage_valid,
  input  logic              stage_we,
  input  logic [REG_AW-1:0] stage_dst,
  input  logic [REG_AW-1:0] src0,
  input  logic              src0_used,
  input  logic [REG_AW-1:0] src1,
  input  logic              src1_used,
  output logic              match
);

  logic dst_live;
  logic src_hit;

  assign dst_live = check_en & stage_valid & stage_we
                  & (stage_dst != REG_AW'(REG_ZERO));
  assign src_hit  = (src0_used & (src0 == stage_dst))
                  | (src1_used & (src1 == stage_dst));
  assign match    = dst_live & src_hit;

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_unit.sv
`default_nettype none
// pipeline_hazard_unit: tracks in-flight instructions as a fixed shift of
// {valid, we, is_jump, dst} tuples and stalls issue on RAW or jump hazards.
module pipeline_hazard_unit
  import pipeline_hazard_unit_pkg::*;
#(
  parameter int STAGES    = STAGES_DEFAULT,
  parameter int REG_AW    = 5,
  parameter int WB_BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_src0,
  input  logic [REG_AW-1:0] issue_src1,
  input  logic              issue_src0_used,
  input  logic              issue_src1_used,
  input  logic [REG_AW-1:0] issue_dst,
  input  logic              issue_dst_we,
  input  logic              issue_is_jump,
  output logic              stall,
  output logic              issue_fire,
  output logic [STAGES-1:0] stage_valid,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_dst,
  output logic [3:0]        inflight
);

  localparam int TUPLE_W = tuple_width(REG_AW);
  localparam int V_BIT   = TUPLE_W - 1;
  localparam int WE_BIT  = TUPLE_W - 2;
  localparam int J_BIT   = TUPLE_W - 3;

  logic [TUPLE_W-1:0]    tuple_q [STAGES];
  logic [TUPLE_W-1:0]    tuple_d [STAGES];
  logic [INFLIGHT_W-1:0] inflight_q;
  logic [INFLIGHT_W-1:0] inflight_d;

  logic [STAGES-1:0] valid_vec;
  logic [STAGES-1:0] jmp_vec;
  logic [STAGES-1:0] match_vec;
  logic              raw_hazard;
  logic              ctrl_hazard;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    assign valid_vec[k] = tuple_q[k][V_BIT];
    assign jmp_vec[k]   = tuple_q[k][J_BIT];

    // With a write-through register file the final stage is already visible.
    hazard_compare #(
      .REG_AW (REG_AW)
    ) u_cmp (
      .check_en    ((WB_BYPASS == 0) || (k != STAGES - 1)),
      .stage_valid (tuple_q[k][V_BIT]),
      .stage_we    (tuple_q[k][WE_BIT]),
      .stage_dst   (tuple_q[k][REG_AW-1:0]),
      .src0        (issue_src0),
      .src0_used   (issue_src0_used),
      .src1        (issue_src1),
      .src1_used   (issue_src1_used),
      .match       (match_vec[k])
    );
  end

  assign raw_hazard  = |match_vec;
  assign ctrl_hazard = |(valid_vec & jmp_vec);
  assign stall       = issue_valid & (raw_hazard | ctrl_hazard);
  assign issue_fire  = issue_valid & ~stall;

  always_comb begin
    tuple_d[0] = {issue_fire,
                  issue_fire & issue_dst_we,
                  issue_fire & issue_is_jump,
                  issue_fire ? issue_dst : '0};
    for (int k = 1; k < STAGES; k++) begin
      tuple_d[k] = tuple_q[k-1];
    end
    inflight_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      inflight_d = inflight_d + INFLIGHT_W'(tuple_d[k][V_BIT]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < STAGES; k++) begin
        tuple_q[k] <= '0;
      end
      inflight_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        tuple_q[k] <= tuple_d[k];
      end
      inflight_q <= inflight_d;
    end
  end

  assign stage_valid = valid_vec;
  assign wb_valid    = tuple_q[STAGES-1][V_BIT];
  assign wb_we       = tuple_q[STAGES-1][V_BIT] & tuple_q[STAGES-1][WE_BIT];
  assign wb_dst      = tuple_q[STAGES-1][REG_AW-1:0];
  assign inflight    = inflight_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_unit.sv
`default_nettype none
// Bench for pipeline_hazard_unit: cycle-by-cycle model comparison on the
// default configuration plus stall-length checks across parameter variants.
module tb_pipeline_hazard_unit;

  localparam int S   = 3;
  localparam int BYP = 1;
  localparam int LIM = (BYP != 0) ? S - 1 : S;  // ages that still block a reader

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       issue_valid;
  logic [4:0] issue_src0, issue_src1, issue_dst;
  logic       issue_src0_used, issue_src1_used, issue_dst_we, issue_is_jump;

  logic       stall, issue_fire, wb_valid, wb_we;
  logic [S-1:0] stage_valid;
  logic [4:0] wb_dst;
  logic [3:0] inflight;

  int n_tests = 0;
  int n_fail  = 0;

  pipeline_hazard_unit #(.STAGES(S), .REG_AW(5), .WB_BYPASS(BYP)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid),
    .issue_src0(issue_src0), .issue_src1(issue_src1),
    .issue_src0_used(issue_src0_used), .issue_src1_used(issue_src1_used),
    .issue_dst(issue_dst), .issue_dst_we(issue_dst_we), .issue_is_jump(issue_is_jump),
    .stall(stall), .issue_fire(issue_fire), .stage_valid(stage_valid),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_dst(wb_dst), .inflight(inflight)
  );

  // Variants: (2,0) (2,1) (8,0) (8,1) (3,0) as (STAGES, WB_BYPASS)
  logic [4:0] sw_stall, sw_fire;
  for (genvar i = 0; i < 5; i++) begin : g_sweep
    localparam int SS = (i < 2) ? 2 : ((i < 4) ? 8 : 3);
    localparam int SB = (i == 1 || i == 3) ? 1 : 0;
    logic [SS-1:0] sv;
    logic          wv, ww;
    logic [4:0]    wd;
    logic [3:0]    inf;
    pipeline_hazard_unit #(.STAGES(SS), .REG_AW(5), .WB_BYPASS(SB)) u_sw (
      .clk(clk), .rst(rst), .issue_valid(issue_valid),
      .issue_src0(issue_src0), .issue_src1(issue_src1),
      .issue_src0_used(issue_src0_used), .issue_src1_used(issue_src1_used),
      .issue_dst(issue_dst), .issue_dst_we(issue_dst_we), .issue_is_jump(issue_is_jump),
      .stall(sw_stall[i]), .issue_fire(sw_fire[i]), .stage_valid(sv),
      .wb_valid(wv), .wb_we(ww), .wb_dst(wd), .inflight(inf)
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: list of in-flight instructions by age
  typedef struct {
    int         age;
    logic [4:0] dst;
    logic       we;
    logic       jmp;
  } rec_t;
  rec_t mq[$];

  function automatic logic m_hazard();
    logic h = 1'b0;
    foreach (mq[i]) begin
      if (mq[i].jmp) h = 1'b1;
      if (mq[i].we && mq[i].dst != 5'd0 && mq[i].age < LIM &&
          ((issue_src0_used && issue_src0 == mq[i].dst) ||
           (issue_src1_used && issue_src1 == mq[i].dst))) h = 1'b1;
    end
    return h;
  endfunction

  always @(posedge clk or negedge rst) begin : m_upd
    logic f;
    rec_t r;
    if (!rst) begin
      mq.delete();
    end else begin
      f = issue_valid && !m_hazard();
      foreach (mq[i]) mq[i].age++;
      while (mq.size() > 0 && mq[$].age >= S) void'(mq.pop_back());
      if (f) begin
        r.age = 0; r.dst = issue_dst; r.we = issue_dst_we; r.jmp = issue_is_jump;
        mq.push_front(r);
      end
    end
  end

  always @(negedge clk) begin : cmp
    logic [7:0] ev;
    logic       ewv, ewe;
    logic [4:0] ewd;
    ev = '0; ewv = 1'b0; ewe = 1'b0; ewd = '0;
    foreach (mq[i]) begin
      ev[mq[i].age] = 1'b1;
      if (mq[i].age == S - 1) begin
        ewv = 1'b1; ewe = mq[i].we; ewd = mq[i].dst;
      end
    end
    chk("m_stall",       32'(stall),       32'(issue_valid && m_hazard()));
    chk("m_issue_fire",  32'(issue_fire),  32'(issue_valid && !m_hazard()));
    chk("m_stage_valid", 32'(stage_valid), 32'(ev[S-1:0]));
    chk("m_wb_valid",    32'(wb_valid),    32'(ewv));
    chk("m_wb_we",       32'(wb_we),       32'(ewe));
    chk("m_wb_dst",      32'(wb_dst),      32'(ewd));
    chk("m_inflight",    32'(inflight),    32'(mq.size()));
  end

  // ---------------- stimulus helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] s0, input logic u0,
                       input logic [4:0] s1, input logic u1,
                       input logic [4:0] d, input logic we, input logic j);
    issue_valid = v; issue_src0 = s0; issue_src0_used = u0;
    issue_src1 = s1; issue_src1_used = u1;
    issue_dst = d; issue_dst_we = we; issue_is_jump = j;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  int cnt_main;
  int cnt_sw [5];

  // Producer writes pd, then a reader of pd is held valid for 12 cycles.
  task automatic run_dep(input logic [4:0] pd, input logic on_src1, input logic used);
    logic       mf;
    logic [4:0] swf;
    step();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, pd, 1'b1, 1'b0);
    step();
    if (on_src1) drive(1'b1, 5'd0, 1'b0, pd, used, 5'd20, 1'b1, 1'b0);
    else         drive(1'b1, pd, used, 5'd0, 1'b0, 5'd20, 1'b1, 1'b0);
    mf = 1'b0; swf = '0; cnt_main = 0;
    for (int i = 0; i < 5; i++) cnt_sw[i] = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (!mf) begin
        if (issue_fire) mf = 1'b1;
        else if (stall) cnt_main++;
      end
      for (int i = 0; i < 5; i++) begin
        if (!swf[i]) begin
          if (sw_fire[i]) swf[i] = 1'b1;
          else if (sw_stall[i]) cnt_sw[i]++;
        end
      end
      step();
    end
    chk("dep_fired", 32'(mf), 32'd1);
    idle();
    repeat (10) step();
  endtask

  int stalls;
  logic [3:0] infl [8];

  initial begin
    rst = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    chk("rst_stall",    32'(stall),    32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_dst",   32'(wb_dst),   32'd0);
    chk("rst_inflight", 32'(inflight), 32'd0);

    // Independent stream r1, r2, r3 issued on the first cycles after release
    for (int c = 0; c < 6; c++) begin
      step();
      if (c == 0) rst = 1'b1;
      if (c < 3) drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'(c + 1), 1'b1, 1'b0);
      else       idle();
      @(negedge clk);
      chk("indep_stall", 32'(stall), 32'd0);
      if (c < 3) chk("indep_fire", 32'(issue_fire), 32'd1);
      if (c >= 3) begin
        chk("indep_wb_valid", 32'(wb_valid), 32'd1);
        chk("indep_wb_dst",   32'(wb_dst),   32'(c - 2));
      end
    end
    repeat (3) step();

    // RAW via src0: default config stalls 2; sweep variants per their depth
    run_dep(5'd4, 1'b0, 1'b1);
    chk("raw_src0_stalls", 32'(cnt_main), 32'd2);
    chk("sweep_s2_b0", 32'(cnt_sw[0]), 32'd2);
    chk("sweep_s2_b1", 32'(cnt_sw[1]), 32'd1);
    chk("sweep_s8_b0", 32'(cnt_sw[2]), 32'd8);
    chk("sweep_s8_b1", 32'(cnt_sw[3]), 32'd7);
    chk("sweep_s3_b0", 32'(cnt_sw[4]), 32'd3);

    run_dep(5'd9, 1'b1, 1'b1);
    chk("raw_src1_stalls", 32'(cnt_main), 32'd2);
    run_dep(5'd10, 1'b0, 1'b0);
    chk("unused_src_stalls", 32'(cnt_main), 32'd0);

    // Register 0 never hazards
    step(); drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    step(); drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd21, 1'b1, 1'b0);
    @(negedge clk);
    chk("r0_stall", 32'(stall), 32'd0);
    chk("r0_fire",  32'(issue_fire), 32'd1);
    step(); idle(); repeat (4) step();

    // Self-dependent instruction on an empty pipeline
    drive(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0);
    @(negedge clk);
    chk("selfdep_stall", 32'(stall), 32'd0);
    step(); idle(); repeat (4) step();

    // Jump holds issue until it leaves the final stage
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    step();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    stalls = 0;
    for (int c = 0; c < 8; c++) infl[c] = 4'hf;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      infl[c] = inflight;
      if (issue_fire) break;
      stalls++;
      step();
    end
    chk("jump_stalls",     32'(stalls),  32'd3);
    chk("jump_inflight_0", 32'(infl[0]), 32'd1);
    chk("jump_inflight_1", 32'(infl[1]), 32'd1);
    chk("jump_inflight_2", 32'(infl[2]), 32'd1);
    chk("jump_inflight_3", 32'(infl[3]), 32'd0);
    step(); idle(); repeat (4) step();

    // Reset asserted with three instructions in flight
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0); step();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0); step();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0); step();
    idle();
    chk("full_stage_valid", 32'(stage_valid), 32'd7);
    chk("full_wb_we",       32'(wb_we),       32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_stage_valid", 32'(stage_valid), 32'd0);
    chk("midrst_wb_we",       32'(wb_we),       32'd0);
    chk("midrst_wb_valid",    32'(wb_valid),    32'd0);
    chk("midrst_inflight",    32'(inflight),    32'd0);
    @(negedge clk);
    chk("midrst_wb_we_neg", 32'(wb_we), 32'd0);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_inflight", 32'(inflight), 32'd0);
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_unit.md
PIPELINE_HAZARD_UNIT -- requirements
Module: pipeline_hazard_unit

Interface
REQ-001 SHALL have parameter STAGES, default 3: in-flight stages after issue (EXE, MEM, WB); legal range 2..8.
REQ-002 SHALL have parameter REG_AW, default 5: register address width.
REQ-003 SHALL have parameter WB_BYPASS, default 1: 1 = register file writes through, so a match in the final stage does not stall.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 issue_valid  input  1  decode holds a valid instruction.
REQ-007 issue_src0, issue_src1  input  REG_AW each  source register addresses.
REQ-008 issue_src0_used, issue_src1_used  input  1 each  the source is actually read.
REQ-009 issue_dst  input  REG_AW  destination register.
REQ-010 issue_dst_we  input  1  the instruction writes issue_dst.
REQ-011 issue_is_jump  input  1  the instruction may redirect the PC.
REQ-012 stall  output  1  hold the PC and issue register this cycle.
REQ-013 issue_fire  output  1  the instruction enters stage 0 at the next edge.
REQ-014 stage_valid  output  STAGES  bit k set = stage k holds a real instruction.
REQ-015 wb_valid, wb_we  output  1 each  final-stage valid, and final-stage write enable.
REQ-016 wb_dst  output  REG_AW  final-stage destination register.
REQ-017 inflight  output  4  count of set bits in stage_valid.

Function
REQ-018 Each stage SHALL hold the tuple {valid, dst, we, is_jump}; every cycle the tuples SHALL shift from stage k to stage k+1 unconditionally (no downstream back-pressure), and the tuple leaving stage STAGES-1 SHALL be dropped.
REQ-019 Stage 0 SHALL load {issue_fire, issue_dst, issue_dst_we, issue_is_jump}; when issue_fire=0 it SHALL load a bubble (valid=0, we=0, is_jump=0).
REQ-020 A RAW hazard SHALL exist when a used source equals the dst of any stage with valid=1 and we=1; when WB_BYPASS=1 the final stage SHALL be excluded from this check.
REQ-021 Register address 0 SHALL never cause a hazard.
REQ-022 A control hazard SHALL exist while any stage with valid=1 holds is_jump=1 (issue is held until the jump retires from the final stage).
REQ-023 stall SHALL equal issue_valid AND (RAW hazard OR control hazard); issue_fire SHALL equal issue_valid AND NOT stall. Both are combinational, same cycle.
REQ-024 With issue_valid=0, stall SHALL be 0 and bubbles SHALL be inserted.
REQ-025 wb_valid, wb_we and wb_dst SHALL come directly from the final stage tuple, with wb_we gated by valid.
REQ-026 inflight SHALL be registered and reflect stage_valid after each edge, with range 0..STAGES.
REQ-027 An instruction that depends on itself (src = dst) SHALL be checked only against older in-flight instructions and SHALL NOT stall itself.
REQ-028 Back-to-back dependent issues SHALL see a stall of STAGES-1 cycles when WB_BYPASS=1, or STAGES cycles when WB_BYPASS=0.

Reset
REQ-029 While rst=0, all stage tuples SHALL clear to zero and inflight SHALL be 0, so stall=0, wb_valid=0, wb_we=0 and wb_dst=0.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight instructions immediately, with no write-back pulse.
REQ-031 The first edge after reset is released SHALL accept an issue if issue_valid=1.

Structure
REQ-032 The tuple width, STAGES default and the register-0 constant SHALL live in the shared arch defines package, alongside the existing stage-width defines.
REQ-033 SHALL instantiate one sub-module, hazard_compare (one stage tuple against both sources -> match), replicated STAGES times; the pipeline shift SHALL stay in the top-level module.
REQ-034 The block SHALL replace the stage counter and the per-stage enable controls in the pipelined CPU.

Verification
REQ-035 Independent stream: issue r1<-, r2<-, r3<- on consecutive cycles with no shared sources -> stall always 0; wb_dst sequence 1,2,3 starting at cycle 3.
REQ-036 RAW with WB_BYPASS=1, STAGES=3: issue dst=r4, then src0=r4 -> stall for exactly 2 cycles, then issue_fire=1.
REQ-037 Register 0: issue dst=r0 we=1, then src0=r0 -> no stall.
REQ-038 Jump: issue is_jump=1, then any instruction -> stall for 3 cycles until the jump leaves WB; inflight goes 1,1,1,0 across those cycles.
REQ-039 Reset mid-flight: 3 instructions in flight, drive rst=0 for 1 cycle -> stage_valid=0 immediately, no wb_we pulse, inflight=0.
REQ-040 Parameter sweep: STAGES=2 and STAGES=8, WB_BYPASS=0/1 -> stall length on the REQ-036 stimulus matches REQ-028 (8 and 7 cycles at STAGES=8).
